// File: rtl/fabric_config_loader_pkg.sv
// Shared types and constants for the fabric configuration loader.
// The CRC constants are used only when CONFIG_READBACK_CRC_EN is defined.
package fabric_config_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StShift,
        StTail,
        StDone
    } loader_state_e;

    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic [15:0] CRC16_INIT = 16'hFFFF;

    // One serial step of CRC-16-CCITT, MSB-first feedback
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
        logic fb;
        fb = crc[15] ^ bit_in;
        return {crc[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/config_crc16.sv
// Serial 1-bit CRC-16-CCITT accumulator with synchronous clear and enable.
// Instanced by fabric_config_loader only when CONFIG_READBACK_CRC_EN is defined.
module config_crc16
    import fabric_config_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        enable,
    input  logic        data,
    output logic [15:0] crc
);

    logic [15:0] crc_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_q <= CRC16_INIT;
        end else if (clear) begin
            crc_q <= CRC16_INIT;
        end else if (enable) begin
            crc_q <= crc16_step(crc_q, data);
        end
    end

    assign crc = crc_q;

endmodule

// File: rtl/fabric_config_loader.sv
// Streams bitstream words LSB-first into the fabric configuration chain with a divided clock.
// Optional readback CRC check is enabled by defining CONFIG_READBACK_CRC_EN.
module fabric_config_loader
    import fabric_config_loader_pkg::*;
#(
    parameter int unsigned CONFIG_WIDTH = 1024,
    parameter int unsigned WORD_WIDTH   = 32,
    parameter int unsigned CLK_DIV      = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    input  logic [WORD_WIDTH-1:0] word_data,
    input  logic                  word_valid,
    output logic                  word_ready,
    output logic                  config_clk,
    output logic                  config_en,
    output logic                  config_in,
    input  logic                  config_out,
    output logic                  fabric_reset,
    output logic                  verify_valid,
    output logic                  verify_ok
);

    localparam int unsigned BitCntW  = $clog2(CONFIG_WIDTH + 1);
    localparam int unsigned WordCntW = $clog2(WORD_WIDTH + 1);
    localparam int unsigned DivW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [BitCntW-1:0]  LastBit     = BitCntW'(CONFIG_WIDTH - 1);
    localparam logic [WordCntW-1:0] LastWordBit = WordCntW'(WORD_WIDTH - 1);
    localparam logic [DivW-1:0]     DivLast     = DivW'(CLK_DIV - 1);

    loader_state_e         state_q;
    logic [DivW-1:0]       div_cnt_q;
    logic [WORD_WIDTH-1:0] buf_q;
    logic [BitCntW-1:0]    bit_cnt_q;
    logic [WordCntW-1:0]   word_bits_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  word_ready_q;
    logic                  cfg_clk_q;
    logic                  cfg_en_q;
    logic                  cfg_in_q;
    logic                  fab_rst_q;

    logic toggle;
    assign toggle = (div_cnt_q == DivLast);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StIdle;
            div_cnt_q    <= '0;
            buf_q        <= '0;
            bit_cnt_q    <= '0;
            word_bits_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            word_ready_q <= 1'b0;
            cfg_clk_q    <= 1'b1;
            cfg_en_q     <= 1'b0;
            cfg_in_q     <= 1'b0;
            fab_rst_q    <= 1'b1;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q      <= StFetch;
                        busy_q       <= 1'b1;
                        done_q       <= 1'b0;
                        fab_rst_q    <= 1'b1;
                        word_ready_q <= 1'b1;
                        bit_cnt_q    <= '0;
                        div_cnt_q    <= '0;
                    end
                end
                StFetch: begin
                    // Divider stays frozen and config_clk stays high until a word arrives
                    if (word_valid) begin
                        buf_q        <= word_data;
                        word_bits_q  <= '0;
                        word_ready_q <= 1'b0;
                        div_cnt_q    <= '0;
                        state_q      <= StShift;
                    end
                end
                StShift: begin
                    if (toggle) begin
                        div_cnt_q <= '0;
                        cfg_clk_q <= !cfg_clk_q;
                        if (cfg_clk_q) begin
                            cfg_in_q <= buf_q[0];
                            buf_q    <= buf_q >> 1;
                            cfg_en_q <= 1'b1;
                        end else begin
                            bit_cnt_q   <= bit_cnt_q + 1'b1;
                            word_bits_q <= word_bits_q + 1'b1;
                            if (bit_cnt_q == LastBit) begin
                                state_q <= StTail;
                            end else if (word_bits_q == LastWordBit) begin
                                state_q      <= StFetch;
                                word_ready_q <= 1'b1;
                            end
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end
                StTail: begin
                    if (toggle) begin
                        div_cnt_q <= '0;
                        cfg_clk_q <= !cfg_clk_q;
                        if (cfg_clk_q) begin
                            cfg_en_q <= 1'b0;
                            cfg_in_q <= 1'b0;
                        end else begin
                            state_q   <= StDone;
                            busy_q    <= 1'b0;
                            done_q    <= 1'b1;
                            fab_rst_q <= 1'b0;
                        end
                    end else begin
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign word_ready   = word_ready_q;
    assign config_clk   = cfg_clk_q;
    assign config_en    = cfg_en_q;
    assign config_in    = cfg_in_q;
    assign fabric_reset = fab_rst_q;

`ifdef CONFIG_READBACK_CRC_EN
    logic        start_fire;
    logic        rise_tgl;
    logic        enter_done;
    logic [15:0] crc_in;
    logic [15:0] crc_out;
    logic [15:0] crc_prev_q;
    logic        prev_valid_q;
    logic        verify_valid_q;
    logic        verify_ok_q;

    assign start_fire = (state_q == StIdle) && start;
    assign rise_tgl   = (state_q == StShift) && toggle && !cfg_clk_q;
    assign enter_done = (state_q == StTail) && toggle && !cfg_clk_q;

    config_crc16 u_crc_in (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (start_fire),
        .enable (rise_tgl),
        .data   (cfg_in_q),
        .crc    (crc_in)
    );

    // config_out is sampled before the fabric shifts on this rising edge
    config_crc16 u_crc_out (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (start_fire),
        .enable (rise_tgl),
        .data   (config_out),
        .crc    (crc_out)
    );

    // The chain ejects the previous load, so compare against the previous crc_in
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            crc_prev_q     <= '0;
            prev_valid_q   <= 1'b0;
            verify_valid_q <= 1'b0;
            verify_ok_q    <= 1'b0;
        end else if (start_fire) begin
            verify_valid_q <= 1'b0;
            verify_ok_q    <= 1'b0;
        end else if (enter_done) begin
            verify_valid_q <= prev_valid_q;
            verify_ok_q    <= prev_valid_q && (crc_out == crc_prev_q);
            crc_prev_q     <= crc_in;
            prev_valid_q   <= 1'b1;
        end
    end

    assign verify_valid = verify_valid_q;
    assign verify_ok    = verify_ok_q;
`else
    logic unused_config_out;
    assign unused_config_out = config_out;
    assign verify_valid      = 1'b0;
    assign verify_ok         = 1'b0;
`endif

endmodule

// File: tb/tb_fabric_config_loader.sv
// Scoreboard bench for fabric_config_loader with a behavioural 40-bit chain model.
// Verify expectations depend on whether CONFIG_READBACK_CRC_EN is defined.
module tb_fabric_config_loader;

    localparam int CW       = 40;
    localparam int WW       = 16;
    localparam int DIV      = 2;
    localparam int NW       = (CW + WW - 1) / WW;
    localparam int LOAD_LAT = 2 * DIV * (CW + 1) + NW;
    localparam int RDY_TO   = 500;
    localparam int DONE_TO  = 3000;
    localparam logic [CW-1:0] LOW8_CLR = ~(40'hFF);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic [WW-1:0] word_data = '0;
    logic          word_valid = 1'b0;
    logic          busy, done, word_ready, config_clk, config_en, config_in, config_out;
    logic          fabric_reset, verify_valid, verify_ok;

    always #5 clk = ~clk;

    fabric_config_loader #(
        .CONFIG_WIDTH(CW),
        .WORD_WIDTH  (WW),
        .CLK_DIV     (DIV)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .busy        (busy),
        .done        (done),
        .word_data   (word_data),
        .word_valid  (word_valid),
        .word_ready  (word_ready),
        .config_clk  (config_clk),
        .config_en   (config_en),
        .config_in   (config_in),
        .config_out  (config_out),
        .fabric_reset(fabric_reset),
        .verify_valid(verify_valid),
        .verify_ok   (verify_ok)
    );

    typedef struct {
        logic [CW-1:0] chain;
        int            lat;
        int            edge_base;
        int            start_cyc;
        logic          vv;
        logic          vo;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          mon_e;
    int            checks = 0;
    int            failures = 0;
    int            cyc = 0;
    int            edges = 0;
    bit            stuck7 = 1'b0;
    logic [CW-1:0] chain = '0;
    logic [CW-1:0] chain_nxt;
    logic          done_prev = 1'b0;
    logic [WW-1:0] words[NW];
    int            dly[NW];
    bit            prev_valid = 1'b0;
    logic [CW-1:0] prev_bits = '0;
    logic [CW-1:0] prev_stored = '0;

    always @(posedge clk) cyc <= cyc + 1;

    // Fabric chain model: new bit enters at the top, tail is bit 0
    assign config_out = chain[0];
    always @(posedge config_clk) begin
        if (config_en === 1'b1) begin
            chain_nxt = {config_in, chain[CW-1:1]};
            if (stuck7) chain_nxt[7] = 1'b0;
            chain <= chain_nxt;
            edges <= edges + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    task automatic check_reset_vals(input string name);
        check(name, {55'd0, config_clk, config_en, config_in, busy, done, word_ready,
                     verify_valid, verify_ok, fabric_reset}, 64'h101);
    endtask

    always @(negedge clk) begin
        if (done && !done_prev) begin
            check("sb_entry_present", sb_q.size() > 0, 1);
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                check("chain_contents", chain, mon_e.chain);
                check("enabled_rise_edges", edges - mon_e.edge_base, CW);
                if (mon_e.lat >= 0) check("load_latency", cyc - mon_e.start_cyc, mon_e.lat);
                check("busy_fabric_reset_at_done", {busy, fabric_reset}, 2'b00);
                check("verify_flags", {verify_valid, verify_ok}, {mon_e.vv, mon_e.vo});
            end
        end
        done_prev = done;
    end

    task automatic run_load(input bit poke_busy, input bit poke_done);
        exp_t          e;
        logic [CW-1:0] bits;
        logic [CW-1:0] stored;
        int            n;
        int            bad;
        bit            stalled;
        bit            zero_delay;
        zero_delay = 1'b1;
        for (int i = 0; i < CW; i++) bits[i] = words[i / WW][i % WW];
        for (int w = 0; w < NW; w++) if (dly[w] != 0) zero_delay = 1'b0;
        // A stuck cell zeroes itself and every bit that had to pass through it
        stored  = stuck7 ? (bits & LOW8_CLR) : bits;
        e.chain = stored;
`ifdef CONFIG_READBACK_CRC_EN
        e.vv = prev_valid;
        e.vo = prev_valid && (prev_stored == prev_bits);
`else
        e.vv = 1'b0;
        e.vo = 1'b0;
`endif
        prev_valid  = 1'b1;
        prev_bits   = bits;
        prev_stored = stored;
        e.lat       = zero_delay ? LOAD_LAT : -1;
        e.edge_base = edges;

        @(negedge clk);
        start      = 1'b1;
        word_data  = words[0];
        word_valid = (dly[0] == 0);
        @(posedge clk);
        #1;
        start       = 1'b0;
        e.start_cyc = cyc;
        sb_q.push_back(e);

        stalled = 1'b0;
        bad     = 0;
        for (int w = 0; w < NW; w++) begin
            word_data  = words[w];
            word_valid = (dly[w] == 0);
            n = 0;
            while (!word_ready && n < RDY_TO) begin
                @(negedge clk);
                n++;
            end
            check("word_ready_timeout", n < RDY_TO, 1);
            if (dly[w] != 0) begin
                repeat (dly[w]) begin
                    @(negedge clk);
                    if (w > 0) begin
                        stalled = 1'b1;
                        if (!(config_clk && config_en)) bad++;
                    end
                end
                word_valid = 1'b1;
            end
            @(posedge clk);
            #1;
            if (w == 0 && poke_busy) begin
                start = 1'b1;
                @(posedge clk);
                #1;
                start = 1'b0;
                check("start_while_busy", {busy, done, fabric_reset}, 3'b101);
            end
        end
        word_valid = 1'b0;
        if (stalled) check("stall_holds_clk_high_en_on", bad, 0);

        n = 0;
        while (!done && n < DONE_TO) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", n < DONE_TO, 1);
        check("no_extra_word_request", word_ready, 0);
        if (poke_done) begin
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            @(negedge clk);
            check("start_in_done_ignored", {busy, done, fabric_reset}, 3'b010);
        end
    endtask

    task automatic abort_load();
        int n;
        int base;
        base = edges;
        @(negedge clk);
        start      = 1'b1;
        word_data  = words[0];
        word_valid = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        while ((edges - base) < 20 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("abort_reached_bit20", edges - base, 20);
        reset_n = 1'b0;
        #1;
        check_reset_vals("reset_mid_load");
        word_valid = 1'b0;
        prev_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic randomize_words(input int max_dly);
        for (int w = 0; w < NW; w++) begin
            words[w] = WW'($urandom);
            dly[w]   = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, max_dly)) : 0;
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("reset_state");
        @(negedge clk);
        reset_n = 1'b1;

        words = '{16'hA5C3, 16'h0FF0, 16'h00E7};
        dly   = '{0, 0, 0};
        run_load(1'b0, 1'b0);
        run_load(1'b0, 1'b1);

        dly = '{0, 50, 0};
        run_load(1'b1, 1'b0);

        abort_load();
        randomize_words(1);
        dly = '{0, 0, 0};
        run_load(1'b0, 1'b0);

        randomize_words(1);
        dly      = '{0, 0, 0};
        words[0] = words[0] | 16'h0080;
        stuck7   = 1'b1;
        run_load(1'b0, 1'b0);
        stuck7 = 1'b0;
        randomize_words(1);
        dly = '{0, 0, 0};
        run_load(1'b0, 1'b0);
        run_load(1'b0, 1'b0);

        repeat (6) begin
            randomize_words(8);
            run_load(1'b0, 1'b0);
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
